// File: rtl/asconp_ctrl.sv
// ---------------------------------------------------------------------------
// asconp_ctrl -- round sequencer for the one-round-per-cycle Ascon-p core.
//
// Accepts a 320-bit state (x0..x4) over a start valid/ready handshake and
// feeds it through the external round core for ROUNDS_A (mode 1) or
// ROUNDS_B (mode 0) rounds. The round counter goes straight to the core's
// round_cnt input. The permuted state is returned over a done valid/ready
// handshake.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   start_valid_i/ready_o   request handshake; mode_i, x0_i..x4_i sampled on accept
//   done_valid_o/ready_i    result handshake; x0_o..x4_o hold the result
//   flush_i                 synchronous abort to IDLE (highest priority)
//   busy_o                  high in RUN or DONE
//   lut_lock_o              high in RUN (S-box LUT writes must be refused)
//   round_cnt_o             round counter C to the core
//   px0_o..px4_o            state register to the core
//   px0_i..px4_i            one-round result from the core
// ---------------------------------------------------------------------------
module asconp_ctrl #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_valid_i,
   output logic        start_ready_o,
   input  logic        mode_i,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic        done_valid_o,
   input  logic        done_ready_i,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        lut_lock_o,
   output logic [3:0]  round_cnt_o,
   output logic [63:0] px0_o,
   output logic [63:0] px1_o,
   output logic [63:0] px2_o,
   output logic [63:0] px3_o,
   output logic [63:0] px4_o,
   input  logic [63:0] px0_i,
   input  logic [63:0] px1_i,
   input  logic [63:0] px2_i,
   input  logic [63:0] px3_i,
   input  logic [63:0] px4_i
);

   // Round counts outside 1..12 cannot be expressed with a counter that
   // always finishes at 11, so reject them at elaboration.
   generate
      if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
         $error("asconp_ctrl: ROUNDS_A must be in 1..12");
      end
      if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
         $error("asconp_ctrl: ROUNDS_B must be in 1..12");
      end
   endgenerate

   // The counter always ends at 11, so a shorter permutation simply starts
   // later in the constant schedule (p^6 starts at 6, p^8 at 4).
   localparam logic [3:0] C_START_A = 4'(12 - ROUNDS_A);
   localparam logic [3:0] C_START_B = 4'(12 - ROUNDS_B);
   localparam logic [3:0] C_LAST    = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [4:0][63:0]  r_s;
   logic [4:0][63:0]  w_s_next;
   logic [3:0]        r_c;
   logic [3:0]        w_c_next;
   logic [4:0][63:0]  w_x_in;
   logic [4:0][63:0]  w_px_in;
   logic              w_start_ready;
   logic              w_done_valid;

   assign w_x_in  = {x4_i, x3_i, x2_i, x1_i, x0_i};
   assign w_px_in = {px4_i, px3_i, px2_i, px1_i, px0_i};

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_c     <= '0;
      end else begin
         r_state <= w_state_next;
         r_s     <= w_s_next;
         r_c     <= w_c_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and handshake logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_s_next      = r_s;
      w_c_next      = r_c;
      w_start_ready = 1'b0;
      w_done_valid  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_start_ready = 1'b1;
            if (start_valid_i) begin
               w_s_next     = w_x_in;
               w_c_next     = mode_i ? C_START_A : C_START_B;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_s_next = w_px_in;
            // The round with C = 11 is the last one; keep C there.
            if (r_c == C_LAST) begin
               w_state_next = ST_DONE;
            end else begin
               w_c_next = r_c + 4'd1;
            end
         end
         ST_DONE: begin
            w_done_valid = 1'b1;
            if (done_ready_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Flush overrides accept and the DONE handshake. The state register
      // keeps its contents; only the counter is cleared.
      if (flush_i) begin
         w_state_next = ST_IDLE;
         w_s_next     = r_s;
         w_c_next     = 4'd0;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign start_ready_o = w_start_ready;
   assign done_valid_o  = w_done_valid;
   assign busy_o        = (r_state != ST_IDLE);
   assign lut_lock_o    = (r_state == ST_RUN);
   assign round_cnt_o   = r_c;

   assign px0_o = r_s[0];
   assign px1_o = r_s[1];
   assign px2_o = r_s[2];
   assign px3_o = r_s[3];
   assign px4_o = r_s[4];

   assign x0_o  = r_s[0];
   assign x1_o  = r_s[1];
   assign x2_o  = r_s[2];
   assign x3_o  = r_s[3];
   assign x4_o  = r_s[4];

endmodule

// File: tb/tb_asconp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_asconp_ctrl -- scoreboard bench for asconp_ctrl.
// Two controllers share the clock and reset: instance 0 with p^12/p^6 and
// instance 1 with p^12/p^8. Each one is wrapped around a behavioural
// Ascon round core. Requests push the reference permutation result into a
// per-instance queue. A monitor pops the queue on every rising
// done_valid_o and compares the result words and the latency.
// ---------------------------------------------------------------------------
module tb_asconp_ctrl;

   typedef logic [4:0][63:0] st_t;

   typedef struct {
      st_t exp;
      int  acc_edge;
      int  rounds;
   } sb_t;

   logic       clk;
   logic       rst_n;
   int         cyc;
   int         n_vec;
   int         n_fail;

   logic       sv       [2];
   logic       sr       [2];
   logic       md       [2];
   logic       dv       [2];
   logic       dr       [2];
   logic       fl       [2];
   logic       busy     [2];
   logic       lock     [2];
   logic [3:0] rc       [2];
   st_t        xin      [2];
   st_t        xout     [2];
   st_t        pxo      [2];
   st_t        pxi      [2];
   logic       rdy_fix  [2];
   logic       rdy_rand [2];
   logic       rnd_bit  [2];

   sb_t        sbq [2][$];

   // ---------------------------------------------------------------------
   // Reference Ascon-p round (constant, S-box layer, linear layer)
   // ---------------------------------------------------------------------
   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic st_t rnd(input st_t s, input logic [3:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0]  k;
      st_t         o;
      k  = 8'hf0 - {c, 4'h0} + {4'h0, c};
      x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, k}; x3 = s[3]; x4 = s[4];
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return o;
   endfunction

   function automatic st_t perm(input st_t s, input int r);
      st_t t;
      t = s;
      for (int i = 12 - r; i < 12; i++) t = rnd(t, 4'(i));
      return t;
   endfunction

   // ---------------------------------------------------------------------
   // DUTs with their round cores
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int RB = (gi == 0) ? 6 : 8;
      asconp_ctrl #(.ROUNDS_A(12), .ROUNDS_B(RB)) dut (
         .clk_i         (clk),
         .rst_n_i       (rst_n),
         .start_valid_i (sv[gi]),
         .start_ready_o (sr[gi]),
         .mode_i        (md[gi]),
         .x0_i          (xin[gi][0]),
         .x1_i          (xin[gi][1]),
         .x2_i          (xin[gi][2]),
         .x3_i          (xin[gi][3]),
         .x4_i          (xin[gi][4]),
         .done_valid_o  (dv[gi]),
         .done_ready_i  (dr[gi]),
         .x0_o          (xout[gi][0]),
         .x1_o          (xout[gi][1]),
         .x2_o          (xout[gi][2]),
         .x3_o          (xout[gi][3]),
         .x4_o          (xout[gi][4]),
         .flush_i       (fl[gi]),
         .busy_o        (busy[gi]),
         .lut_lock_o    (lock[gi]),
         .round_cnt_o   (rc[gi]),
         .px0_o         (pxo[gi][0]),
         .px1_o         (pxo[gi][1]),
         .px2_o         (pxo[gi][2]),
         .px3_o         (pxo[gi][3]),
         .px4_o         (pxo[gi][4]),
         .px0_i         (pxi[gi][0]),
         .px1_i         (pxi[gi][1]),
         .px2_i         (pxi[gi][2]),
         .px3_i         (pxi[gi][3]),
         .px4_i         (pxi[gi][4])
      );
      assign pxi[gi] = rnd(pxo[gi], rc[gi]);
      assign dr[gi]  = rdy_rand[gi] ? rnd_bit[gi] : rdy_fix[gi];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input int k, input string tag);
      chk({tag, "_start_ready"}, 320'(sr[k]),   320'(1));
      chk({tag, "_done_valid"},  320'(dv[k]),   320'(0));
      chk({tag, "_busy"},        320'(busy[k]), 320'(0));
      chk({tag, "_lut_lock"},    320'(lock[k]), 320'(0));
      chk({tag, "_round_cnt"},   320'(rc[k]),   320'(0));
      chk({tag, "_x_out"},       xout[k],       320'(0));
      chk({tag, "_px_out"},      pxo[k],        320'(0));
   endtask

   // abort_kind: 0 = run to completion, 1 = flush at round abort_at,
   // 2 = asynchronous reset at round abort_at.
   task automatic issue(input int k, input logic mode, input st_t st,
                        input int abort_kind, input int abort_at,
                        input logic check_rc, output st_t exp);
      int         r;
      int         w;
      int         acc;
      logic [7:0] first_k;
      logic [7:0] got_k;
      r = mode ? 12 : ((k == 0) ? 6 : 8);
      first_k = (r == 12) ? 8'hf0 : ((r == 6) ? 8'h96 : 8'hb4);
      exp = perm(st, r);
      @(negedge clk);
      sv[k] = 1'b1; md[k] = mode; xin[k] = st;
      w = 0;
      while (!sr[k] && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!sr[k]) begin
         n_vec++; n_fail++;
         $display("FAIL accept_timeout: inst %0d start_ready still 0 after %0d cycles", k, w);
         sv[k] = 1'b0;
         return;
      end
      acc = cyc + 1;
      if (abort_kind == 0) sbq[k].push_back('{exp, acc, r});
      @(negedge clk);
      sv[k] = 1'b0;
      for (int i = 0; i < r; i++) begin
         if (abort_kind == 1 && i == abort_at) begin
            fl[k] = 1'b1;
            @(negedge clk);
            fl[k] = 1'b0;
            chk("flush_busy",        320'(busy[k]), 320'(0));
            chk("flush_lut_lock",    320'(lock[k]), 320'(0));
            chk("flush_start_ready", 320'(sr[k]),   320'(1));
            chk("flush_round_cnt",   320'(rc[k]),   320'(0));
            chk("flush_done_valid",  320'(dv[k]),   320'(0));
            return;
         end
         if (abort_kind == 2 && i == abort_at) begin
            #3 rst_n = 1'b0;
            #1 chk_reset_outputs(k, "async_rst");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_start_ready", 320'(sr[k]), 320'(1));
            return;
         end
         if (check_rc) begin
            chk("round_cnt", 320'(rc[k]), 320'(12 - r + i));
            chk("lut_lock_run", 320'(lock[k]), 320'(1));
            if (i == 0) begin
               got_k = 8'hf0 - {rc[k], 4'h0} + {4'h0, rc[k]};
               chk("first_constant", 320'(got_k), 320'(first_k));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int k);
      int w;
      w = 0;
      while ((!sr[k] || dv[k]) && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!sr[k] || dv[k]) begin
         n_vec++; n_fail++;
         $display("FAIL idle_timeout: inst %0d not idle after %0d cycles", k, w);
      end
   endtask

   // ---------------------------------------------------------------------
   // Stimulus, with the monitor forked off as its own process
   // ---------------------------------------------------------------------
   initial begin
      st_t e;
      st_t v;
      int  w;
      n_vec = 0; n_fail = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sv[k] = 1'b0; md[k] = 1'b0; fl[k] = 1'b0; xin[k] = '0;
         rdy_fix[k] = 1'b1; rdy_rand[k] = 1'b0; rnd_bit[k] = 1'b0;
      end

      fork
         begin : monitor
            logic prev [2];
            sb_t  ent;
            prev[0] = 1'b0; prev[1] = 1'b0;
            forever begin
               @(negedge clk);
               for (int k = 0; k < 2; k++) begin
                  rnd_bit[k] = 1'($urandom_range(0, 1));
                  if (!rst_n) begin
                     prev[k] = 1'b0;
                  end else begin
                     if (dv[k] && !prev[k]) begin
                        if (sbq[k].size() == 0) begin
                           n_vec++; n_fail++;
                           $display("FAIL extra_beat: inst %0d done_valid with no request outstanding at cycle %0d", k, cyc);
                        end else begin
                           ent = sbq[k].pop_front();
                           chk("result", xout[k], ent.exp);
                           chk("latency", 320'(cyc - ent.acc_edge), 320'(ent.rounds));
                           $display("inst %0d: result beat, %0d rounds, done at cycle %0d", k, ent.rounds, cyc);
                        end
                     end
                     prev[k] = dv[k];
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk_reset_outputs(0, "reset0");
      chk_reset_outputs(1, "reset1");
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release_ready", 320'(sr[0]), 320'(1));

      // p^12 on the all-zero state
      issue(0, 1'b1, '0, 0, 0, 1'b1, e);
      wait_idle(0);

      // p^6 on instance 0, p^8 and p^12 on instance 1
      v = {64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d,
           64'h0123456789abcdef, 64'hfedcba9876543210};
      issue(0, 1'b0, v, 0, 0, 1'b1, e);
      wait_idle(0);
      v = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
           64'h4444444444444444, 64'h5555555555555555};
      issue(1, 1'b0, v, 0, 0, 1'b1, e);
      wait_idle(1);
      issue(1, 1'b1, v, 0, 0, 1'b0, e);
      wait_idle(1);

      // Backpressure: hold done_ready low for five DONE cycles
      rdy_fix[0] = 1'b0;
      v = {64'h80400c0600000000, 64'h0, 64'hffffffffffffffff, 64'h1, 64'h8000000000000000};
      issue(0, 1'b1, v, 0, 0, 1'b0, e);
      for (int j = 0; j < 5; j++) begin
         chk("bp_done_valid",  320'(dv[0]),   320'(1));
         chk("bp_start_ready", 320'(sr[0]),   320'(0));
         chk("bp_busy",        320'(busy[0]), 320'(1));
         chk("bp_lut_lock",    320'(lock[0]), 320'(0));
         chk("bp_x_out",       xout[0],       e);
         sv[0] = (j == 0 || j == 2) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      sv[0] = 1'b0;
      rdy_fix[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 320'(sr[0]),   320'(1));
      chk("bp_release_valid", 320'(dv[0]),   320'(0));
      chk("bp_release_busy",  320'(busy[0]), 320'(0));

      // Flush at round 3 of p^12, then a clean request
      v = {64'habcdef0123456789, 64'h13579bdf2468ace0, 64'h0, 64'h5a5a5a5a5a5a5a5a, 64'hc3c3c3c3c3c3c3c3};
      issue(0, 1'b1, v, 1, 3, 1'b1, e);
      repeat (14) @(negedge clk);
      chk("flush_no_beat", 320'(dv[0]), 320'(0));
      issue(0, 1'b1, v, 0, 0, 1'b0, e);
      wait_idle(0);

      // Asynchronous reset mid-RUN, then a clean request
      issue(0, 1'b1, v, 2, 4, 1'b0, e);
      issue(0, 1'b0, v, 0, 0, 1'b0, e);
      wait_idle(0);

      // Back-to-back with random modes and random ready gaps
      rdy_rand[0] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         for (int q = 0; q < 5; q++) v[q] = {$urandom, $urandom};
         issue(0, 1'($urandom_range(0, 1)), v, 0, 0, 1'b0, e);
      end
      w = 0;
      while ((sbq[0].size() != 0 || dv[0]) && w < 500) begin
         @(negedge clk);
         w++;
      end
      rdy_rand[0] = 1'b0;
      repeat (4) @(negedge clk);

      chk("missing_beats_0", 320'(sbq[0].size()), 320'(0));
      chk("missing_beats_1", 320'(sbq[1].size()), 320'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/asconp_ctrl.md
# asconp_ctrl

Round sequencer for the Ascon permutation datapath. It accepts a 320-bit state over a valid/ready handshake and iterates the one-round-per-cycle `asconp_lut` core for `ROUNDS_A` or `ROUNDS_B` rounds. It drives the core's `round_cnt` so the correct round constants are applied, then returns the permuted state over a second valid/ready handshake. It also locks the S-box LUT configuration port while a permutation is in flight.

## Interface
Parameters:
- `ROUNDS_A`, default 12: rounds for mode 1 (p^a); legal range 1..12.
- `ROUNDS_B`, default 6: rounds for mode 0 (p^b); legal range 1..12.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n_i` in 1: reset, asynchronous active-low.
- `start_valid_i` in 1: request valid.
- `start_ready_o` out 1: request accepted when valid & ready.
- `mode_i` in 1: 1 = `ROUNDS_A`, 0 = `ROUNDS_B`; sampled on accept.
- `x0_i` .. `x4_i` in 64 each: input state words; sampled on accept.
- `done_valid_o` out 1: result valid.
- `done_ready_i` in 1: result consumed when valid & ready.
- `x0_o` .. `x4_o` out 64 each: result state (the internal state register).
- `flush_i` in 1: synchronous abort.
- `busy_o` out 1: high in RUN or DONE.
- `lut_lock_o` out 1: high in RUN; the top level uses it to NACK S-box LUT register writes.
- `round_cnt_o` out 4: to the core's `round_cnt`.
- `px0_o` .. `px4_o` out 64 each: to the core's `x*_i` (the state register).
- `px0_i` .. `px4_i` in 64 each: from the core's `x*_o` (the one-round result).

## Operation
- State register S (5×64) and round counter C (4 bits).
- FSM states: IDLE, RUN, DONE.
  - **IDLE**: `start_ready_o` = 1. On accept:
    - S ← `x*_i`.
    - C ← 12 − R, where R = `mode_i` ? `ROUNDS_A` : `ROUNDS_B`.
    - Go to RUN.
  - **RUN**: every cycle, S ← `px*_i` and C ← C + 1.
    - When C = 11 (the final round is being applied), go to DONE instead of incrementing.
    - `start_valid_i` is ignored.
  - **DONE**: `done_valid_o` = 1 and S is held.
    - On `done_ready_i` = 1, go to IDLE.
    - No new request is accepted in the same cycle; `start_ready_o` = 0 in DONE.
- Round constant: `round_cnt_o` = C directly. The core XORs `0xf0 − 0x10·C + C` into x2.
  - 12 rounds: constants 0xf0 … 0x4b.
  - 6 rounds: constants start at 0x96.
  - 8 rounds: constants start at 0xb4.
- Outputs driven straight from registers:
  - `px*_o` = S and `x*_o` = S.
  - `x*_o` are meaningful only while `done_valid_o` = 1.
- `flush_i` (any state) → IDLE next edge. S is not cleared, C ← 0, and no `done_valid_o` pulse is produced. `flush_i` has priority over accept and over the DONE handshake.
- Out-of-range parameters (0 or >12) are a configuration error, caught by an elaboration-time assertion.

## Timing
- Reset values: FSM = IDLE, S = 0, C = 0. Resulting outputs:
  - `start_ready_o` = 1.
  - `done_valid_o` = 0, `busy_o` = 0, `lut_lock_o` = 0.
  - `round_cnt_o` = 0, and all `x*_o`/`px*_o` = 0.
- Latency: with the accept at edge 0, rounds are applied at edges 1..R. `done_valid_o` rises after edge R, so the result is visible R cycles after the accept.
- Throughput: one permutation per R+2 cycles minimum (accept, R rounds, one DONE cycle with `done_ready_i` = 1, then IDLE).
- `done_valid_o` and the `x*_o` values are stable while valid & !ready.
- Asynchronous reset mid-RUN: immediate return to reset values; any partial state is discarded.
- `flush_i` in the same cycle as an accept: the request is dropped and the FSM stays in IDLE.
- S-box LUT writes during RUN are blocked externally via `lut_lock_o`. The S-box contents therefore never change mid-permutation.

## Test plan
- **Reset.** Assert `rst_n_i` = 0 mid-RUN → all outputs return to their reset values asynchronously; after release, `start_ready_o` = 1.
- **p^12 on the zero state.** mode 1, x0..x4 = 0, `done_ready_i` = 1:
  - `round_cnt_o` sequences 0,1,…,11 on consecutive cycles.
  - `done_valid_o` rises exactly 12 cycles after the accept.
  - The result matches the golden Ascon-p model.
- **p^6 and p^8.** mode 0 with `ROUNDS_B` = 6 → `round_cnt_o` 6..11, first constant 0x96, done after 6 cycles. Repeat with `ROUNDS_B` = 8 → starts at 4 (0xb4), done after 8 cycles. Results match the model.
- **Backpressure.** Hold `done_ready_i` = 0 for 5 cycles in DONE:
  - Outputs stay stable and `start_ready_o` = 0.
  - `start_valid_i` pulses are ignored.
  - When `done_ready_i` is raised, IDLE follows one cycle later.
- **Flush.** Assert `flush_i` at round 3 of p^12 → IDLE next cycle, no `done_valid_o`, `lut_lock_o` = 0. A subsequent request completes correctly.
- **Back-to-back.** Issue 4 random requests with random modes and random ready gaps → all 4 results match the model, in order, with no extra or missing `done_valid_o` beats.
